// File: rtl/pcs_40g_pkg.sv
// Shared constants for the 40GBASE-R receive PCS: lane alignment-marker
// codes, the control sync header, the lock FSM states and the per-block
// BIP3 contribution.
package pcs_40g_pkg;

  localparam int LANE_N = 4;

  localparam logic [1:0] AM_HEAD = 2'b10;

  // Marker bytes M0..M2 per PCS lane.
  localparam logic [7:0] AM_M0 [LANE_N] = '{8'h90, 8'hF0, 8'hC5, 8'hA2};
  localparam logic [7:0] AM_M1 [LANE_N] = '{8'h76, 8'hC4, 8'h65, 8'h79};
  localparam logic [7:0] AM_M2 [LANE_N] = '{8'h47, 8'hE6, 8'h9B, 8'h3D};

  typedef enum logic [1:0] {
    FIND_1ST = 2'd0,
    WAIT_2ND = 2'd1,
    LOCKED   = 2'd2
  } am_state_t;

  // BIP3 contribution of one 66b block. Payload bit j sits at 66b position
  // j+2, so BIP bit k folds payload bits k, k+8, ... (a bytewise XOR).
  // The two sync header bits land in BIP bits 3 and 4.
  function automatic logic [7:0] bip3_calc(input logic [1:0]  head,
                                           input logic [63:0] data);
    logic [7:0] b;
    b = '0;
    for (int n = 0; n < 8; n++) begin
      b = b ^ data[8*n +: 8];
    end
    b[3] = b[3] ^ head[0];
    b[4] = b[4] ^ head[1];
    return b;
  endfunction

endpackage

// File: rtl/am_bip3_acc.sv
// Running BIP3 over one alignment-marker period. The output holds the parity
// of every valid block seen since (and including) the last restart block.
module am_bip3_acc
  import pcs_40g_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        valid,
  input  logic        restart,
  input  logic [1:0]  head,
  input  logic [63:0] data,
  output logic [7:0]  bip
);

  logic [7:0] bip_reg;
  logic [7:0] blk_bip;

  assign blk_bip = bip3_calc(head, data);
  assign bip     = bip_reg;

  // Reload with the marker's own parity on restart, otherwise fold in.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      bip_reg <= '0;
    end else if (valid) begin
      bip_reg <= restart ? blk_bip : (bip_reg ^ blk_bip);
    end
  end

endmodule

// File: rtl/pcs_40g_rx_am_lock.sv
// Per-lane alignment-marker lock for the 40GBASE-R receive PCS. Finds the
// periodic marker, learns the PCS lane number, tracks lock with a bad-marker
// counter, tags marker blocks for removal and checks BIP3 per period.
// The block datapath is a single register stage; all flags line up with it.
module pcs_40g_rx_am_lock
  import pcs_40g_pkg::*;
#(
  parameter int AM_GAP    = 16383,
  parameter int CNT_W     = $clog2(AM_GAP + 1),
  parameter int INVLD_MAX = 4
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        block_lock_i,
  input  logic        valid_i,
  input  logic [1:0]  head_i,
  input  logic [63:0] data_i,
  output logic        valid_o,
  output logic [1:0]  head_o,
  output logic [63:0] data_o,
  output logic        am_v_o,
  output logic        am_lock_o,
  output logic [1:0]  lane_id_o,
  output logic        bip_err_o
);

  localparam int INV_W = $clog2(INVLD_MAX + 1);

  am_state_t          state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [INV_W-1:0]   invld_reg;
  logic [1:0]         lane_tmp_reg;

  logic [LANE_N-1:0]  lane_match;
  logic               compl_ok;
  logic               match_any;
  logic [1:0]         match_id;
  logic               at_slot;
  logic               am_pos;
  logic [7:0]         bip_acc;
  logic               bip_mis;

  // Bytes 4..6 must be the inverse of bytes 0..2 for any lane's marker.
  assign compl_ok = (head_i == AM_HEAD) && (data_i[55:32] == ~data_i[23:0]);

  generate
    for (genvar gi = 0; gi < LANE_N; gi++) begin : g_match
      assign lane_match[gi] = compl_ok &&
                              (data_i[7:0]   == AM_M0[gi]) &&
                              (data_i[15:8]  == AM_M1[gi]) &&
                              (data_i[23:16] == AM_M2[gi]);
    end
  endgenerate

  assign match_any = |lane_match;

  // Marker codes are distinct, so at most one lane can match.
  always_comb begin
    match_id = '0;
    for (int i = 0; i < LANE_N; i++) begin
      if (lane_match[i]) match_id = 2'(i);
    end
  end

  // While searching any marker starts a period; otherwise only the slot does.
  assign at_slot = (cnt_reg == CNT_W'(AM_GAP));
  assign am_pos  = (state_reg == FIND_1ST) ? match_any : at_slot;
  assign bip_mis = (bip_acc != data_i[31:24]);

  am_bip3_acc u_bip3 (
    .clk     (clk),
    .nreset  (nreset),
    .valid   (valid_i),
    .restart (am_pos && block_lock_i),
    .head    (head_i),
    .data    (data_i),
    .bip     (bip_acc)
  );

  // Lock FSM, block counter and the registered output stage.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg    <= FIND_1ST;
      cnt_reg      <= '0;
      invld_reg    <= '0;
      lane_tmp_reg <= '0;
      valid_o      <= 1'b0;
      head_o       <= '0;
      data_o       <= '0;
      am_v_o       <= 1'b0;
      am_lock_o    <= 1'b0;
      lane_id_o    <= '0;
      bip_err_o    <= 1'b0;
    end else begin
      valid_o   <= valid_i;
      head_o    <= head_i;
      data_o    <= data_i;
      am_v_o    <= 1'b0;
      bip_err_o <= 1'b0;
      if (!block_lock_i) begin
        state_reg <= FIND_1ST;
        am_lock_o <= 1'b0;
        invld_reg <= '0;
      end else if (valid_i) begin
        cnt_reg <= am_pos ? '0 : cnt_reg + CNT_W'(1);
        case (state_reg)
          FIND_1ST: begin
            if (match_any) begin
              lane_tmp_reg <= match_id;
              am_v_o       <= 1'b1;
              state_reg    <= WAIT_2ND;
            end
          end
          WAIT_2ND: begin
            if (at_slot) begin
              bip_err_o <= bip_mis;
              if (match_any && (match_id == lane_tmp_reg)) begin
                am_lock_o <= 1'b1;
                lane_id_o <= lane_tmp_reg;
                am_v_o    <= 1'b1;
                state_reg <= LOCKED;
              end else begin
                state_reg <= FIND_1ST;
              end
            end
          end
          LOCKED: begin
            if (at_slot) begin
              // Position is trusted while locked, so the slot is always a marker.
              bip_err_o <= bip_mis;
              am_v_o    <= 1'b1;
              if (match_any && (match_id == lane_id_o)) begin
                invld_reg <= '0;
              end else if (invld_reg == INV_W'(INVLD_MAX - 1)) begin
                am_lock_o <= 1'b0;
                invld_reg <= '0;
                state_reg <= FIND_1ST;
              end else begin
                invld_reg <= invld_reg + INV_W'(1);
              end
            end
          end
          default: state_reg <= FIND_1ST;
        endcase
      end
    end
  end

endmodule
